add_driver: RTL and testbench

ADD_DRIVER -- requirements
Module: add_driver

---
 rtl/add_driver.sv | 169 ++++++++++++++++
 tb/tb_add_driver.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_driver.sv
// Drives a handshake-less adder from a small operand-pair FIFO and captures its sum.
// Build option: define ADD_DRIVER_STAGGER_EN to drop IEB two cycles after IEA on release.
module add_driver #(
    parameter int unsigned BITS  = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BITS-1:0] in_a,
    input  logic [BITS-1:0] in_b,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [BITS-1:0] a,
    output logic [BITS-1:0] b,
    output logic            iea,
    output logic            ieb,
    input  logic [BITS-1:0] y,
    input  logic            oe,
    output logic [BITS-1:0] res,
    output logic            res_valid,
    output logic            busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StAssert,
        StWaitOe,
        StRelease,
        StWaitNoe
    } state_t;

    state_t state_q, state_d;

    logic [BITS-1:0] mem_a [DEPTH];
    logic [BITS-1:0] mem_b [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;
    logic            push, pop;

    logic [BITS-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic            iea_q, iea_d, ieb_q, ieb_d, rv_q, rv_d;
`ifdef ADD_DRIVER_STAGGER_EN
    logic            stg_q, stg_d;
`endif

    assign in_ready = (count_q != FullCnt);
    assign push     = in_valid && in_ready;
    // Pop reads only registered FIFO state, so a fresh push is never bypassed to the adder.
    assign pop      = (state_q == StIdle) && (count_q != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr_q] <= in_a;
            mem_b[wr_ptr_q] <= in_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        iea_d   = iea_q;
        ieb_d   = ieb_q;
        res_d   = res_q;
        rv_d    = 1'b0;
`ifdef ADD_DRIVER_STAGGER_EN
        stg_d   = stg_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    state_d = StSetup;
                    a_d     = mem_a[rd_ptr_q];
                    b_d     = mem_b[rd_ptr_q];
                    iea_d   = 1'b0;
                    ieb_d   = 1'b0;
                end
            end
            StSetup: begin
                state_d = StAssert;
                iea_d   = 1'b1;
                ieb_d   = 1'b1;
            end
            StAssert: state_d = StWaitOe;
            StWaitOe: begin
                if (oe) begin
                    state_d = StRelease;
                    res_d   = y;
                    rv_d    = 1'b1;
                    iea_d   = 1'b0;
`ifndef ADD_DRIVER_STAGGER_EN
                    ieb_d   = 1'b0;
`endif
                end
            end
            StRelease: begin
`ifdef ADD_DRIVER_STAGGER_EN
                // One spare cycle, then IEB falls two edges after IEA.
                if (stg_q) begin
                    stg_d   = 1'b0;
                    ieb_d   = 1'b0;
                    state_d = StWaitNoe;
                end else begin
                    stg_d = 1'b1;
                end
`else
                state_d = StWaitNoe;
`endif
            end
            StWaitNoe: begin
                if (!oe) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            iea_q   <= 1'b0;
            ieb_q   <= 1'b0;
            res_q   <= '0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            iea_q   <= iea_d;
            ieb_q   <= ieb_d;
            res_q   <= res_d;
            rv_q    <= rv_d;
        end
    end

`ifdef ADD_DRIVER_STAGGER_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stg_q <= 1'b0;
        else     stg_q <= stg_d;
    end
`endif

    assign a         = a_q;
    assign b         = b_q;
    assign iea       = iea_q;
    assign ieb       = ieb_q;
    assign res       = res_q;
    assign res_valid = rv_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_add_driver.sv
// Self-checking bench for add_driver: adder responder, FIFO/result scoreboard, directed
// and randomized scenarios.
module tb_add_driver;

    localparam int BITS  = 8;
    localparam int DEPTH = 4;
`ifdef ADD_DRIVER_STAGGER_EN
    localparam int ExpGap = 2;
`else
    localparam int ExpGap = 0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [BITS-1:0] in_a, in_b, a, b, y, res;
    logic            in_valid, in_ready, iea, ieb, oe, res_valid, busy;

    add_driver #(.BITS(BITS), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
        .in_ready(in_ready), .a(a), .b(b), .iea(iea), .ieb(ieb), .y(y), .oe(oe),
        .res(res), .res_valid(res_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int n_rv     = 0;

    // Scoreboard: expected sums in acceptance order, and occupancy of the operand FIFO.
    logic [BITS-1:0] exp_q[$];
    int              m_q      = 0;
    logic [BITS-1:0] last_res = '0;
    logic            prev_rv  = 1'b0;

    // Adder responder configuration and state.
    int              oe_delay    = 4;
    int              oe_hold     = 1;
    bit              rand_timing = 1'b0;
    int              ad_ph       = 0;
    int              ad_cnt      = 0;
    int              ad_dly      = 0;
    int              ad_hold     = 0;
    logic [BITS-1:0] ad_lat      = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 2000 && (exp_q.size() != 0 || busy); k++) tick();
        check(tag, (exp_q.size() == 0 && !busy), 1);
    endtask

    // Adder model: latches on IE rise, raises OE after a delay, drops it a while after IEs fall.
    initial begin
        oe = 1'b0;
        y  = 8'hA5;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                oe    = 1'b0;
                ad_ph = 0;
            end else begin
                case (ad_ph)
                    0: if (iea && ieb) begin
                        ad_lat  = a + b;
                        ad_cnt  = 0;
                        ad_dly  = rand_timing ? int'($urandom_range(1, 6)) : oe_delay;
                        ad_hold = rand_timing ? int'($urandom_range(0, 3)) : oe_hold;
                        ad_ph   = 1;
                    end
                    1: begin
                        ad_cnt++;
                        if (ad_cnt >= ad_dly) begin
                            oe    = 1'b1;
                            y     = ad_lat;
                            ad_ph = 2;
                        end
                    end
                    2: if (!iea && !ieb) begin
                        ad_cnt = 0;
                        ad_ph  = 3;
                    end
                    default: begin
                        ad_cnt++;
                        if (ad_cnt >= ad_hold) begin
                            oe    = 1'b0;
                            y     = BITS'($urandom);
                            ad_ph = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Monitor: samples pre-edge values, checks IN_READY occupancy and every RES capture.
    initial begin
        logic            do_push, do_pop;
        logic [BITS-1:0] s;
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                exp_q.delete();
                m_q      = 0;
                last_res = '0;
                prev_rv  = 1'b0;
            end else begin
                check("in_ready", in_ready, m_q < DEPTH);
                if (res_valid) begin
                    n_rv++;
                    check("rv_pulse", prev_rv, 0);
                    if (exp_q.size() == 0) check("res_unexpected", res_valid, 0);
                    else begin
                        s = exp_q.pop_front();
                        check("res", res, s);
                        last_res = s;
                    end
                end else begin
                    check("res_hold", res, last_res);
                end
                prev_rv = res_valid;
                do_push = in_valid && (m_q < DEPTH);
                do_pop  = !busy && (m_q > 0);
                if (do_push) begin
                    s = in_a + in_b;
                    exp_q.push_back(s);
                end
                m_q = m_q + int'(do_push) - int'(do_pop);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   rv0, first_block, i, guard, n, fa, fb, k, viol, hold_seen, idle_cnt;
        logic pa, pb, done, fell, got_rv, rdy;
        logic [BITS-1:0] got;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        #3;
        check("rst_iea", iea, 0);
        check("rst_ieb", ieb, 0);
        check("rst_a", a, 0);
        check("rst_b", b, 0);
        check("rst_res", res, 0);
        check("rst_rv", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        tick(); tick();
        rst = 1'b0;

        // Single pair (3,3).
        in_a = 3; in_b = 3; in_valid = 1'b1;
        rv0 = n_rv;
        tick();
        in_valid = 1'b0;
        tick();
        check("t1_a", a, 3);
        check("t1_b", b, 3);
        check("t1_ie_setup", {iea, ieb}, 0);
        check("t1_busy", busy, 1);
        tick();
        check("t1_iea", iea, 1);
        check("t1_ieb", ieb, 1);
        done = 1'b0;
        for (k = 0; k < 60 && !done; k++) begin
            tick();
            if (!busy) done = 1'b1;
        end
        check("t1_idle", done, 1);
        check("t1_rv_count", n_rv - rv0, 1);
        check("t1_res", res, 6);
        check("t1_oe_low", oe, 0);

        // Back-to-back (i,i) for i=0..6; FIFO fills behind a slow adder.
        oe_delay = 6;
        rv0 = n_rv; i = 0; guard = 0; first_block = -1;
        while (i < 7 && guard < 400) begin
            in_a = BITS'(i); in_b = BITS'(i); in_valid = 1'b1;
            rdy = in_ready;
            tick();
            if (rdy) i++;
            else if (first_block < 0) first_block = i;
            guard++;
        end
        in_valid = 1'b0;
        check("t2_pushed", i, 7);
        check("t2_fill", first_block, DEPTH + 1);
        drain("t2_drain");
        check("t2_rv_count", n_rv - rv0, 7);

        // IE release ordering with pair (5,2).
        oe_delay = 3; oe_hold = 1;
        in_a = 5; in_b = 2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        fa = -1; fb = -1; pa = 1'b0; pb = 1'b0; got = '0;
        for (k = 0; k < 60; k++) begin
            tick();
            if (pa && !iea && fa < 0) fa = k;
            if (pb && !ieb && fb < 0) fb = k;
            pa = iea; pb = ieb;
            if (res_valid) got = res;
        end
        check("t3_fell", (fa >= 0 && fb >= 0), 1);
        check("t3_gap", fb - fa, ExpGap);
        check("t3_res", got, 7);

        // OE held high long after release; next pair must wait for OE low.
        oe_hold = 10;
        in_a = 1; in_b = 2; in_valid = 1'b1;
        tick();
        in_a = 4; in_b = 4;
        tick();
        in_valid = 1'b0;
        viol = 0; hold_seen = 0; idle_cnt = 0; fell = 1'b0; got_rv = 1'b0; done = 1'b0;
        for (k = 0; k < 120 && !done; k++) begin
            tick();
            if (res_valid) got_rv = 1'b1;
            if (got_rv && !iea && !ieb) fell = 1'b1;
            if (fell && oe) begin
                hold_seen++;
                if (a !== 1 || b !== 2 || iea || ieb) viol++;
            end
            if (fell && !busy) idle_cnt++;
            if (fell && idle_cnt > 0 && busy) begin
                check("t4_next_a", a, 4);
                check("t4_next_b", b, 4);
                done = 1'b1;
            end
        end
        check("t4_done", done, 1);
        check("t4_stable", viol, 0);
        check("t4_hold_seen", hold_seen >= 8, 1);
        check("t4_idle_cycles", idle_cnt, 1);
        drain("t4_drain");
        oe_hold = 1;

        // Randomized pairs, gaps and adder timing.
        rand_timing = 1'b1;
        rv0 = n_rv; n = 0;
        for (k = 0; k < 3000 && n < 20; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_a = BITS'($urandom); in_b = BITS'($urandom);
            rdy = in_ready;
            tick();
            if (in_valid && rdy) n++;
        end
        in_valid = 1'b0;
        check("t5_pushed", n, 20);
        drain("t5_drain");
        check("t5_rv_count", n_rv - rv0, 20);
        rand_timing = 1'b0;

        // Asynchronous reset in WAIT_OE with two pairs queued.
        oe_delay = 30;
        n = 0;
        for (k = 0; k < 50 && n < 3; k++) begin
            in_a = BITS'(k + 10); in_b = 1; in_valid = 1'b1;
            rdy = in_ready;
            tick();
            if (rdy) n++;
        end
        in_valid = 1'b0;
        done = 1'b0;
        for (k = 0; k < 50 && !done; k++) begin
            if (iea) done = 1'b1;
            else tick();
        end
        check("t6_ie_seen", done, 1);
        tick(); tick();
        #1 rst = 1'b1;
        #1;
        check("t6_iea", iea, 0);
        check("t6_ieb", ieb, 0);
        check("t6_in_ready", in_ready, 1);
        check("t6_busy", busy, 0);
        check("t6_a", a, 0);
        tick(); tick();
        rst = 1'b0;
        rv0 = n_rv;
        repeat (60) tick();
        check("t6_no_rv", n_rv - rv0, 0);
        check("t6_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
